// File: rtl/fwd_hazard_ctrl.sv
// Forwarding/stall controller for a 5-stage MIPS pipeline: Tnew/Tuse scoreboard per post-D stage.
// Optional HI/LO busy interlock is built when MD_STALL_EN is defined.
module fwd_hazard_ctrl #(
    parameter int unsigned STAGES = 3,
    parameter int unsigned TW     = 2,
    parameter int unsigned MD_LAT = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           d_valid,
    input  logic [4:0]                     d_rs,
    input  logic [4:0]                     d_rt,
    input  logic [TW-1:0]                  d_tuse_rs,
    input  logic [TW-1:0]                  d_tuse_rt,
    input  logic                           d_we,
    input  logic [4:0]                     d_a3,
    input  logic [TW-1:0]                  d_tnew,
    input  logic [4:0]                     e_rs,
    input  logic [4:0]                     e_rt,
    input  logic                           flush,
    input  logic                           d_is_md,
    input  logic                           d_md_start,
    output logic                           stall,
    output logic [$clog2(STAGES+1)-1:0]    fwd_rs_d,
    output logic [$clog2(STAGES+1)-1:0]    fwd_rt_d,
    output logic [$clog2(STAGES+1)-1:0]    fwd_rs_e,
    output logic [$clog2(STAGES+1)-1:0]    fwd_rt_e,
    output logic                           md_busy
);

    localparam int unsigned SW = $clog2(STAGES + 1);
    localparam logic [TW-1:0] TUSE_NONE = '1;

    typedef struct packed {
        logic          hit;
        logic [SW-1:0] idx;
        logic [TW-1:0] tn;
    } match_t;

    // Slot k holds the writer k stages past D (1=E, 2=M, 3=W, ...)
    logic [STAGES:1]          v_q,  v_d;
    logic [STAGES:1][4:0]     a3_q, a3_d;
    logic [STAGES:1][TW-1:0]  tn_q, tn_d;

    logic   md_stall;
    match_t m_rs_d, m_rt_d, m_rs_e, m_rt_e;
    logic   haz_rs, haz_rt;

    // Youngest valid writer of r among slots lo..STAGES; $0 never matches.
    function automatic match_t lookup(
        input logic [4:0]               r,
        input int                       lo,
        input logic [STAGES:1]          v,
        input logic [STAGES:1][4:0]     a3,
        input logic [STAGES:1][TW-1:0]  tn
    );
        match_t m;
        m = '0;
        for (int k = int'(STAGES); k >= lo; k--) begin
            if (v[k] && (a3[k] == r) && (r != 5'd0)) begin
                m.hit = 1'b1;
                m.idx = SW'(k);
                m.tn  = tn[k];
            end
        end
        return m;
    endfunction

    always_comb begin
        m_rs_d = lookup(d_rs, 1, v_q, a3_q, tn_q);
        m_rt_d = lookup(d_rt, 1, v_q, a3_q, tn_q);
        m_rs_e = lookup(e_rs, 2, v_q, a3_q, tn_q);
        m_rt_e = lookup(e_rt, 2, v_q, a3_q, tn_q);
    end

    assign haz_rs = m_rs_d.hit && (d_tuse_rs != TUSE_NONE) && (m_rs_d.tn > d_tuse_rs);
    assign haz_rt = m_rt_d.hit && (d_tuse_rt != TUSE_NONE) && (m_rt_d.tn > d_tuse_rt);
    assign stall  = d_valid && (haz_rs || haz_rt || md_stall);

    // Selects are forced to 0 while stalled; a non-ready match is picked up later in E.
    always_comb begin
        fwd_rs_d = '0;
        fwd_rt_d = '0;
        fwd_rs_e = '0;
        fwd_rt_e = '0;
        if (!stall) begin
            if (m_rs_d.hit && (m_rs_d.tn == '0)) fwd_rs_d = m_rs_d.idx;
            if (m_rt_d.hit && (m_rt_d.tn == '0)) fwd_rt_d = m_rt_d.idx;
            if (m_rs_e.hit && (m_rs_e.tn == '0)) fwd_rs_e = m_rs_e.idx;
            if (m_rt_e.hit && (m_rt_e.tn == '0)) fwd_rt_e = m_rt_e.idx;
        end
    end

    always_comb begin
        v_d  = '0;
        a3_d = a3_q;
        tn_d = tn_q;
        for (int k = 2; k <= int'(STAGES); k++) begin
            v_d[k]  = v_q[k-1];
            a3_d[k] = a3_q[k-1];
            tn_d[k] = (tn_q[k-1] == '0) ? '0 : tn_q[k-1] - TW'(1);
        end
        v_d[1]  = d_valid && d_we && !stall && !flush;
        a3_d[1] = d_a3;
        tn_d[1] = d_tnew;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
        end else begin
            v_q  <= v_d;
            a3_q <= a3_d;
            tn_q <= tn_d;
        end
    end

`ifdef MD_STALL_EN
    localparam int unsigned CW = ($clog2(MD_LAT + 1) > 3) ? $clog2(MD_LAT + 1) : 3;

    logic [CW-1:0] md_cnt_q, md_cnt_d;

    // Busy countdown for the HI/LO unit; a start while busy is held off by the stall.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (d_md_start && !stall) begin
            md_cnt_d = CW'(MD_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy  = (md_cnt_q != '0);
    assign md_stall = d_is_md && md_busy;
`else
    logic unused_md;
    assign unused_md = ^{d_is_md, d_md_start, 32'(MD_LAT)};
    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs, d_rt, d_a3, e_rs, e_rt;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_we, flush, d_is_md, d_md_start;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

`ifdef MD_STALL_EN
    localparam logic MD_ON = 1'b1;
`else
    localparam logic MD_ON = 1'b0;
`endif

    fwd_hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_we       (d_we),
        .d_a3       (d_a3),
        .d_tnew     (d_tnew),
        .e_rs       (e_rs),
        .e_rt       (e_rt),
        .flush      (flush),
        .d_is_md    (d_is_md),
        .d_md_start (d_md_start),
        .stall      (stall),
        .fwd_rs_d   (fwd_rs_d),
        .fwd_rt_d   (fwd_rt_d),
        .fwd_rs_e   (fwd_rs_e),
        .fwd_rt_e   (fwd_rt_e),
        .md_busy    (md_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // {stall, md_busy, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e}
    function automatic logic [9:0] pk(input logic s, input logic b, input logic [1:0] rsd,
                                      input logic [1:0] rtd, input logic [1:0] rse, input logic [1:0] rte);
        return {s, b, rsd, rtd, rse, rte};
    endfunction

    task automatic expect_out(input string name, input logic s, input logic [1:0] rsd, input logic [1:0] rtd,
                              input logic [1:0] rse, input logic [1:0] rte, input logic b);
        exp_t e;
        e.name = name;
        e.exp  = pk(s, b, rsd, rtd, rse, rte);
        q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [9:0] act;
        if (q.size() != 0) begin
            e   = q.pop_front();
            act = pk(stall, md_busy, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e);
            compared++;
            if (act !== e.exp) begin
                mismatched++;
                $display("FAIL %s: got stall=%b busy=%b rs_d=%0d rt_d=%0d rs_e=%0d rt_e=%0d, expected stall=%b busy=%b rs_d=%0d rt_d=%0d rs_e=%0d rt_e=%0d",
                         e.name, act[9], act[8], act[7:6], act[5:4], act[3:2], act[1:0],
                         e.exp[9], e.exp[8], e.exp[7:6], e.exp[5:4], e.exp[3:2], e.exp[1:0]);
            end
        end
    end

    task automatic idle();
        d_valid = 0; d_rs = 0; d_rt = 0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
        d_we = 0; d_a3 = 0; d_tnew = 0; e_rs = 0; e_rt = 0;
        flush = 0; d_is_md = 0; d_md_start = 0;
    endtask

    task automatic drive_d(input logic we, input logic [4:0] a3, input logic [1:0] tnew,
                           input logic [4:0] rs, input logic [1:0] tu_rs,
                           input logic [4:0] rt, input logic [1:0] tu_rt);
        d_valid = 1; d_we = we; d_a3 = a3; d_tnew = tnew;
        d_rs = rs; d_tuse_rs = tu_rs; d_rt = rt; d_tuse_rt = tu_rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    initial begin
        reset = 1;
        idle();
        repeat (3) tick();
        reset = 0;
        expect_out("reset_state", 0, 0, 0, 0, 0, 0);
        tick();

        // Load-use: lw $8 (tnew 2) then add rs=$8 (tuse 1)
        drive_d(1, 5'd8, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3);
        expect_out("lu_lw_issue", 0, 0, 0, 0, 0, 0);
        tick();
        drive_d(1, 5'd10, 2'd1, 5'd8, 2'd1, 5'd0, 2'd1);
        expect_out("lu_stall", 1, 0, 0, 0, 0, 0);
        tick();
        expect_out("lu_release", 0, 0, 0, 0, 0, 0);
        tick();
        idle(); e_rs = 5'd8;
        expect_out("lu_fwd_e_w", 0, 0, 0, 3, 0, 0);
        tick();
        drain();

        // ALU-ALU: add $9 (tnew 1) then consumer rs=$9 (tuse 1)
        drive_d(1, 5'd9, 2'd1, 5'd0, 2'd3, 5'd0, 2'd3);
        tick();
        drive_d(1, 5'd12, 2'd1, 5'd9, 2'd1, 5'd11, 2'd1);
        expect_out("alu_no_stall", 0, 0, 0, 0, 0, 0);
        tick();
        idle(); e_rs = 5'd9; e_rt = 5'd11;
        expect_out("alu_fwd_e_m", 0, 0, 0, 2, 0, 0);
        tick();
        drain();

        // Branch: add $9 (tnew 1) then beq rs=$9 (tuse 0)
        drive_d(1, 5'd9, 2'd1, 5'd0, 2'd3, 5'd0, 2'd3);
        tick();
        drive_d(0, 5'd0, 2'd0, 5'd9, 2'd0, 5'd0, 2'd0);
        expect_out("br_stall", 1, 0, 0, 0, 0, 0);
        tick();
        expect_out("br_fwd_d_m", 0, 2, 0, 0, 0, 0);
        tick();
        idle(); e_rs = 5'd9;
        expect_out("br_fwd_e_w", 0, 0, 0, 3, 0, 0);
        tick();
        drain();

        // Priority: two writers of $5 with tnew 0
        drive_d(1, 5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
        tick();
        drive_d(1, 5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
        expect_out("pri_second", 0, 0, 0, 0, 0, 0);
        tick();
        drive_d(0, 5'd0, 2'd0, 5'd5, 2'd1, 5'd0, 2'd3);
        expect_out("pri_fwd_d_e", 0, 1, 0, 0, 0, 0);
        tick();
        drive_d(0, 5'd0, 2'd0, 5'd5, 2'd1, 5'd5, 2'd1);
        e_rs = 5'd5;
        expect_out("pri_youngest", 0, 2, 2, 2, 0, 0);
        tick();
        drain();

        // Shadowing: older ready $7 hidden by younger lw $7
        drive_d(1, 5'd7, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
        tick();
        drive_d(1, 5'd7, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3);
        tick();
        drive_d(0, 5'd0, 2'd0, 5'd7, 2'd1, 5'd0, 2'd3);
        expect_out("shadow_stall", 1, 0, 0, 0, 0, 0);
        tick();
        drain();

        // $0 writer never matches
        drive_d(1, 5'd0, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3);
        tick();
        drive_d(0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
        expect_out("zero_no_stall", 0, 0, 0, 0, 0, 0);
        tick();
        drain();

        // Flush squashes the writer entering E
        drive_d(1, 5'd13, 2'd1, 5'd0, 2'd3, 5'd0, 2'd3);
        flush = 1;
        tick();
        flush = 0;
        drive_d(0, 5'd0, 2'd0, 5'd13, 2'd0, 5'd0, 2'd3);
        expect_out("flush_bubble", 0, 0, 0, 0, 0, 0);
        tick();
        drain();

        // Reset arriving during a load-use stall
        drive_d(1, 5'd8, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3);
        tick();
        drive_d(0, 5'd0, 2'd0, 5'd8, 2'd0, 5'd0, 2'd3);
        reset = 1;
        expect_out("rst_pre_stall", 1, 0, 0, 0, 0, 0);
        tick();
        reset = 0;
        e_rs = 5'd8;
        expect_out("rst_clears", 0, 0, 0, 0, 0, 0);
        tick();
        drain();

        // mult then mfhi
        drive_d(0, 5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
        d_is_md = 1; d_md_start = 1;
        expect_out("md_start", 0, 0, 0, 0, 0, 0);
        tick();
        drive_d(1, 5'd14, 2'd1, 5'd0, 2'd3, 5'd0, 2'd3);
        d_is_md = 1; d_md_start = 0;
        for (int i = 0; i < 5; i++) begin
            expect_out($sformatf("md_wait%0d", i), MD_ON, 0, 0, 0, 0, MD_ON);
            tick();
        end
        expect_out("md_go", 0, 0, 0, 0, 0, 0);
        tick();
        drain();

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain_timeout: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Parametrised forwarding and stall controller for the 5-stage MIPS pipeline.
- Tracks in-flight register writers in a shift-register scoreboard, one slot per post-D stage.
- Each slot holds the destination register and a Tnew countdown; each consumer supplies a Tuse.
- Compares Tnew against Tuse to generate D-stage stall and forward-select codes for the D and E read ports.

Parameters:
STAGES, 3, number of scoreboard slots (slot 1=E, 2=M, 3=W, ...); select width SW=$clog2(STAGES+1)
TW, 2, width of Tnew/Tuse fields
MD_LAT, 5, mult/div busy cycles (used only with MD_STALL_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
d_valid  in  1  D holds a real instruction
d_rs, d_rt  in  5 each  D source registers
d_tuse_rs, d_tuse_rt  in  TW each  cycles after D until operand needed; all-ones = not used
d_we  in  1  D instruction writes GPR
d_a3  in  5  D destination register
d_tnew  in  TW  cycles after entering E until result forwardable
e_rs, e_rt  in  5 each  E source registers
flush  in  1  squash the instruction entering E
d_is_md, d_md_start  in  1 each  D uses HI/LO / D starts mult/div
stall  out  1  freeze F/D, bubble into E
fwd_rs_d, fwd_rt_d  out  SW each  D operand source: 0=regfile, k=slot k
fwd_rs_e, fwd_rt_e  out  SW each  E operand source: 0=pipeline register, k=slot k (k>=2)
md_busy  out  1  mult/div unit busy

Behaviour:
- Slot state per k: v_k, a3_k[4:0], tn_k[TW-1:0].
- match_k(r) = v_k & (a3_k==r) & (r!=0); $0 never matches.
- Stall (combinational): stall=1 if d_valid and, for either port p with Tuse!=all-ones, the youngest (smallest k) matching slot has tn_k > tuse_p.
- Only the youngest match is considered; older matches are shadowed.
- fwd_*_d = k if the youngest match has tn_k==0; otherwise 0.
  - A nonzero-Tnew match without stall resolves later via the E selects.
- fwd_*_e: same rule applied over slots 2..STAGES only, using e_rs/e_rt.
- Selects are don't-care (driven 0) while stall=1.
- Every posedge, when reset=0:
  - Slot k>=2 <= slot k-1, with tn decremented and saturating at 0.
  - Slot STAGES contents are discarded.
  - Slot 1 <= {1, d_a3, d_tnew} if d_valid & d_we & !stall & !flush; otherwise bubble (v=0).
  - stall and flush together: bubble.
- Latency: the scoreboard updates one cycle after D presents; no other pipelining.
- Reset: all v_k=0, md counter=0.
  - Therefore stall=0, all selects=0, md_busy=0 in the cycle after reset, including when reset arrives mid-stall.

Optional Feature:
MD_STALL_EN
- Defined:
  - A 3-bit-minimum counter loads MD_LAT when d_md_start & !stall, then decrements to 0.
  - md_busy = (cnt!=0).
  - stall is additionally asserted when d_valid & d_is_md & md_busy.
  - A start while busy cannot occur (it is stalled).
  - Counter cleared by reset.
- Undefined:
  - d_is_md and d_md_start are ignored; md_busy is tied 0.
  - No counter is built.

Test Plan:
- Load-use: lw $8 (d_tnew=2); next D add rs=$8 tuse=1 -> stall=1 for exactly 1 cycle; then fwd_rs_d=0; next cycle e_rs=$8 -> fwd_rs_e=3.
- ALU-ALU: add $9 (tnew=1); next D rs=$9 tuse=1 -> no stall, fwd_rs_d=0; following cycle e_rs=$9 -> fwd_rs_e=2.
- Branch: add $9 (tnew=1); next D beq rs=$9 tuse=0 -> stall 1 cycle; then fwd_rs_d=2.
- Priority and $0: slots 2 and 3 both hold a3=$5 with tn=0, D rs=$5 -> fwd_rs_d=2; writer with a3=$0 -> selects stay 0, no stall.
- Flush/reset: flush with a writer in D -> next cycle slot 1 invalid, no match; reset asserted during a load-use stall -> next cycle stall=0, all selects 0.
- MD_STALL_EN, MD_LAT=5: mult issued, then mfhi in D one cycle later -> stall for 5 cycles (md_busy falls to 0), then mfhi proceeds; macro undefined -> no stall.
